// File: rtl/irq_pending_ctrl8_if.sv
// Bundle of the request, mask, encoder-loop and handshake signals for
// irq_pending_ctrl8. The slave modport is the controller; the master modport
// is whatever sits around it (request sources, encoder, consumer).
interface irq_pending_ctrl8_if;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] pend_vec;
    logic [2:0] enc_id;
    logic       enc_valid;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic [7:0] pending;

    modport slave (
        input  irq_in,
        input  mask_we,
        input  mask_wdata,
        output pend_vec,
        input  enc_id,
        input  enc_valid,
        output irq_req,
        output irq_id,
        input  irq_ack,
        output pending
    );

    modport master (
        output irq_in,
        output mask_we,
        output mask_wdata,
        input  pend_vec,
        output enc_id,
        output enc_valid,
        input  irq_req,
        input  irq_id,
        output irq_ack,
        input  pending
    );
endinterface

// File: rtl/irq_pending_ctrl8.sv
// Interrupt pending/handshake controller feeding an external 8-input priority
// encoder. Requests are latched into a pending register, hidden by a software
// mask, and the encoder's pick is presented to the consumer with a req/ack
// handshake; the acknowledged bit is cleared.
// Build option: define IRQ_EDGE_DETECT_EN to capture rising edges of irq_in;
// left undefined, every cycle a line is high sets its pending bit (level mode).
module irq_pending_ctrl8 (
    input  logic                    clk,
    input  logic                    rst_n,
    irq_pending_ctrl8_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_pending;
    logic [7:0] r_mask;
    logic [2:0] r_irq_id;
    logic       r_irq_req;

    logic [7:0] w_set;
    logic [7:0] w_clr;

`ifdef IRQ_EDGE_DETECT_EN
    logic [7:0] r_irq_prev;

    // Remember last cycle's request lines so only 0->1 transitions set pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_prev <= 8'h00;
        end else begin
            r_irq_prev <= bus.irq_in;
        end
    end

    assign w_set = bus.irq_in & ~r_irq_prev;
`else
    assign w_set = bus.irq_in;
`endif

    // Acknowledge clears only the bit currently being requested, and only in REQ.
    always_comb begin
        w_clr = 8'h00;
        if (r_state == S_REQ && bus.irq_ack) begin
            w_clr = 8'(1) << r_irq_id;
        end
    end

    // Pending register: a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= 8'h00;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Software mask; writing it never touches pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask <= 8'h00;
        end else if (bus.mask_we) begin
            r_mask <= bus.mask_wdata;
        end
    end

    // Handshake FSM: latch the encoder pick, hold it until ack, then give the
    // encoder one cycle to see the cleared vector before choosing again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_irq_id  <= 3'd0;
            r_irq_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.enc_valid) begin
                        r_irq_id  <= bus.enc_id;
                        r_irq_req <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.irq_ack) begin
                        r_irq_req <= 1'b0;
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_irq_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pend_vec = r_pending & ~r_mask;
    assign bus.pending  = r_pending;
    assign bus.irq_req  = r_irq_req;
    assign bus.irq_id   = r_irq_id;

endmodule
